// File: rtl/usb_rx_unstuff_deser_pkg.sv
// Shared types and defaults for the USB receive-path bit unstuffer / deserialiser.
package usb_phy_pkg;

  typedef enum logic [1:0] {IDLE, RUN, SKIP, ERR} state_e;

  localparam int unsigned USB_STUFF_LEN = 6;
  localparam int unsigned USB_DATA_W    = 8;

endpackage

// File: rtl/usb_rx_unstuff_deser_if.sv
// Bit-stream input and word/strobe output bundle between the NRZI decoder and the packet decoder.
interface usb_rx_unstuff_deser_if
  import usb_phy_pkg::*;
#(
  parameter int unsigned DATA_W   = USB_DATA_W,
  parameter int unsigned ERRCNT_W = 8
);

  logic                rx_active;
  logic                data_enable;
  logic                bit_in;
  logic [DATA_W-1:0]   data_out;
  logic                data_valid;
  logic                stuff_err;
  logic                frame_err;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output rx_active, data_enable, bit_in,
    input  data_out, data_valid, stuff_err, frame_err, err_count
  );

  modport slave (
    input  rx_active, data_enable, bit_in,
    output data_out, data_valid, stuff_err, frame_err, err_count
  );

endinterface

// File: rtl/usb_rx_unstuff_deser.sv
// Removes and checks stuffed bits, then packs the LSB-first stream into DATA_W-bit words.
// Optional saturating error counter enabled by macro UNSTUFF_ERR_CNT_EN.
module usb_rx_unstuff_deser
  import usb_phy_pkg::*;
#(
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN,
  parameter int unsigned DATA_W    = USB_DATA_W,
  parameter int unsigned ERRCNT_W  = 8
) (
  input logic                   clk,
  input logic                   reset,
  usb_rx_unstuff_deser_if.slave bus
);

  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_W + 1);

  state_e              state;
  logic [ONES_W-1:0]   ones_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shreg;

  logic [DATA_W-1:0]   data_out_q;
  logic                data_valid_q;
  logic                stuff_err_q;
  logic                frame_err_q;

  logic [DATA_W-1:0]   shreg_next;
  logic [ONES_W-1:0]   ones_next;
  logic [IDX_W-1:0]    idx_next;
  logic                run_bit;
  logic                skip_bit;
  logic                word_done;
  logic                stuff_hit;
  logic                abort;

  always_comb begin
    shreg_next = {bus.bit_in, shreg[DATA_W-1:1]};
    ones_next  = bus.bit_in ? ones_cnt + ONES_W'(1) : '0;
    idx_next   = bit_idx + IDX_W'(1);
    run_bit    = bus.rx_active && bus.data_enable && (state == RUN);
    skip_bit   = bus.rx_active && bus.data_enable && (state == SKIP);
    word_done  = run_bit && (idx_next == IDX_W'(DATA_W));
    stuff_hit  = (ones_next == ONES_W'(STUFF_LEN));
    // A trailing stuff bit may legitimately be missing, so only a held partial word is an error.
    abort      = !bus.rx_active && ((state == RUN) || (state == SKIP)) && (bit_idx != '0);
  end

  // Stuff tracker and deserialiser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ones_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (!bus.rx_active) begin
      state    <= IDLE;
      ones_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (bus.data_enable) begin
            shreg   <= shreg_next;
            bit_idx <= word_done ? '0 : idx_next;
            // Run length carries across word boundaries; only a zero or a stuff slot resets it.
            if (stuff_hit) begin
              state    <= SKIP;
              ones_cnt <= '0;
            end else begin
              ones_cnt <= ones_next;
            end
          end
        end
        SKIP: begin
          if (bus.data_enable) begin
            state <= bus.bit_in ? ERR : RUN;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered strobes and word output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= word_done;
      stuff_err_q  <= skip_bit && bus.bit_in;
      frame_err_q  <= abort;
      if (word_done) begin
        data_out_q <= shreg_next;
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.stuff_err  = stuff_err_q;
  assign bus.frame_err  = frame_err_q;

`ifdef UNSTUFF_ERR_CNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  // Survives packet boundaries; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if ((stuff_err_q || frame_err_q) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule
